// File: rtl/ps2_key_ctrl.sv
// PS/2 key sequencer: decodes key words into maze move/action commands,
// suppresses typematic repeats, tracks held direction keys and queues
// commands in a small FIFO drained through a valid/ack handshake.
module ps2_key_ctrl #(
  parameter int FIFO_AW         = 2,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         key_code,
  input  logic               key_ready_n,
  output logic               cmd_valid,
  output logic [2:0]         cmd,
  input  logic               cmd_ack,
  output logic [3:0]         held,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  // Key identity; the command code is key_id + 1.
  typedef enum logic [2:0] {
    K_UP    = 3'd0,
    K_DOWN  = 3'd1,
    K_LEFT  = 3'd2,
    K_RIGHT = 3'd3,
    K_ENTER = 3'd4,
    K_ESC   = 3'd5
  } key_id_e;

  logic       w_expand;
  logic       w_break;
  logic [7:0] w_scan;
  assign w_expand = key_code[9];
  assign w_break  = key_code[8];
  assign w_scan   = key_code[7:0];

  // ---------------------------------------------------------------------
  // Strobe edge detect: a low level of any length is a single event.
  // ---------------------------------------------------------------------
  logic r_ready_n_d;
  logic w_strobe;
  assign w_strobe = ~key_ready_n & r_ready_n_d;

  // Remember the previous strobe level for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) r_ready_n_d <= 1'b1;
    else     r_ready_n_d <= key_ready_n;
  end

  // ---------------------------------------------------------------------
  // Key map: expand bit must match the table exactly.
  // ---------------------------------------------------------------------
  logic    w_map_hit;
  key_id_e w_map_key;

  // Translate the scan code into a key identity, or flag it unmapped.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; without
    // them an unmatched case would hold its value and infer a latch.
    w_map_hit = 1'b0;
    w_map_key = K_UP;
    if (w_expand) begin
      unique case (w_scan)
        8'h75:   begin w_map_hit = 1'b1; w_map_key = K_UP;    end
        8'h72:   begin w_map_hit = 1'b1; w_map_key = K_DOWN;  end
        8'h6B:   begin w_map_hit = 1'b1; w_map_key = K_LEFT;  end
        8'h74:   begin w_map_hit = 1'b1; w_map_key = K_RIGHT; end
        default: ;
      endcase
    end else begin
      unique case (w_scan)
        8'h1D:   begin w_map_hit = 1'b1; w_map_key = K_UP;    end
        8'h1B:   begin w_map_hit = 1'b1; w_map_key = K_DOWN;  end
        8'h1C:   begin w_map_hit = 1'b1; w_map_key = K_LEFT;  end
        8'h23:   begin w_map_hit = 1'b1; w_map_key = K_RIGHT; end
        8'h5A:   begin w_map_hit = 1'b1; w_map_key = K_ENTER; end
        8'h76:   begin w_map_hit = 1'b1; w_map_key = K_ESC;   end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: register the decoded event on the capture cycle.
  // ---------------------------------------------------------------------
  logic    r_s1_valid;
  logic    r_s1_brk;
  key_id_e r_s1_key;

  // Capture one decoded event per strobe; unmapped codes never enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_brk   <= 1'b0;
      r_s1_key   <= K_UP;
    end else begin
      r_s1_valid <= w_strobe & w_map_hit;
      r_s1_brk   <= w_break;
      r_s1_key   <= w_map_key;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: held-key tracking and command generation.
  // Bits [3:0] are directions (visible), [5:4] ENTER/ESC (internal).
  // ---------------------------------------------------------------------
  logic [5:0] r_held;
  logic       w_was_held;
  logic       w_push;
  logic [2:0] w_cmd_in;

  assign w_was_held = r_held[r_s1_key];
  assign w_push     = r_s1_valid & ~r_s1_brk & ~(SUPPRESS_REPEAT & w_was_held);
  assign w_cmd_in   = 3'(r_s1_key) + 3'd1;
  assign held       = r_held[3:0];

  // Make sets and break clears the key's held bit, even if its command is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held <= '0;
    end else if (r_s1_valid) begin
      r_held[r_s1_key] <= ~r_s1_brk;
    end
  end

  // ---------------------------------------------------------------------
  // Command FIFO: circular buffer with occupancy counter.
  // ---------------------------------------------------------------------
  logic [2:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_pop;
  logic               w_push_ok;

  assign w_full     = (r_count == DEPTH_C);
  assign cmd_valid  = (r_count != '0);
  assign w_pop      = cmd_valid & cmd_ack;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign cmd        = cmd_valid ? r_mem[r_rd_ptr] : 3'd0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Write storage for accepted commands.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and counter
    // are, so stale entries are never presented after reset.
    if (w_push_ok) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  // Advance pointers and occupancy on accepted pushes and pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_overflow <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    else if (ovf_clr)                r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: stimulus pushes expected commands,
// a monitor pops and compares on every accepted handshake.
// Key word layout is {expand, break, scancode[7:0]}.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_code;
  logic       key_ready_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ack;
  logic [3:0] held;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  ps2_key_ctrl #(.FIFO_AW(2), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_ready_n (key_ready_n),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ack     (cmd_ack),
    .held        (held),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One key event; optionally assert cmd_ack / ovf_clr in the push cycle (low=1 only).
  task automatic send_key(input logic [9:0] code, input int low = 1,
                          input logic ack_at_push = 1'b0, input logic clr_at_push = 1'b0);
    key_code    = code;
    key_ready_n = 1'b0;
    repeat (low) tick();
    key_ready_n = 1'b1;
    cmd_ack     = ack_at_push;
    ovf_clr     = clr_at_push;
    tick();
    cmd_ack     = 1'b0;
    ovf_clr     = 1'b0;
  endtask

  task automatic drain(input int n);
    cmd_ack = 1'b1;
    repeat (n) tick();
    cmd_ack = 1'b0;
  endtask

  // Monitor: every accepted handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {29'd0, cmd}, 32'hFFFF_FFFF);
      end else begin
        check("cmd_order", {29'd0, cmd}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  logic [9:0] wrap_make [10] = '{10'h01D, 10'h01B, 10'h01C, 10'h023, 10'h05A,
                                 10'h076, 10'h275, 10'h272, 10'h26B, 10'h274};
  logic [2:0] wrap_exp  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    rst = 1'b1; key_code = '0; key_ready_n = 1'b1; cmd_ack = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_held", held, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // 1: E0-75 make -> UP at N+2, then acknowledged
    send_key(10'h275); exp_q.push_back(3'd1);
    check("t1_valid", cmd_valid, 1);
    check("t1_cmd", cmd, 1);
    check("t1_held", held, 4'b0001);
    drain(1);
    check("t1_valid_after_ack", cmd_valid, 0);
    check("t1_count_after_ack", fifo_count, 0);
    send_key(10'h375);
    check("t1_held_release", held, 0);

    // 2: repeated W makes -> one command; break clears held only
    send_key(10'h01D); exp_q.push_back(3'd1);
    send_key(10'h01D);
    send_key(10'h01D);
    tick();
    check("t2_count", fifo_count, 1);
    check("t2_held", held, 4'b0001);
    send_key(10'h11D);
    tick();
    check("t2_held_break", held, 0);
    check("t2_count_break", fifo_count, 1);
    drain(1);
    check("t2_count_drained", fifo_count, 0);

    // 3: five commands into depth 4 with no ack -> ENTER dropped
    send_key(10'h275); exp_q.push_back(3'd1); send_key(10'h375);
    send_key(10'h272); exp_q.push_back(3'd2); send_key(10'h372);
    send_key(10'h26B); exp_q.push_back(3'd3); send_key(10'h36B);
    send_key(10'h274); exp_q.push_back(3'd4); send_key(10'h374);
    check("t3_overflow_before", overflow, 0);
    send_key(10'h05A); send_key(10'h15A);
    check("t3_count", fifo_count, 4);
    check("t3_overflow", overflow, 1);
    check("t3_held", held, 0);
    drain(4);
    check("t3_count_drained", fifo_count, 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t3_overflow_cleared", overflow, 0);

    // 4: push + pop while full, then ten wrapping push/pop rounds
    send_key(10'h01D); exp_q.push_back(3'd1); send_key(10'h11D);
    send_key(10'h01B); exp_q.push_back(3'd2); send_key(10'h11B);
    send_key(10'h01C); exp_q.push_back(3'd3); send_key(10'h11C);
    send_key(10'h023); exp_q.push_back(3'd4); send_key(10'h123);
    check("t4_full", fifo_count, 4);
    send_key(10'h05A, 1, 1'b1); exp_q.push_back(3'd5);
    check("t4_count_pushpop", fifo_count, 4);
    check("t4_overflow_pushpop", overflow, 0);
    send_key(10'h15A);
    for (int i = 0; i < 10; i++) begin
      send_key(wrap_make[i], 1, 1'b1); exp_q.push_back(wrap_exp[i]);
      check($sformatf("t4_wrap_count_%0d", i), fifo_count, 4);
      send_key(wrap_make[i] | 10'h100);
    end
    check("t4_overflow_wrap", overflow, 0);
    drain(4);
    check("t4_count_drained", fifo_count, 0);

    // 5: unmapped codes ignored; long strobe counts once
    send_key(10'h01D); exp_q.push_back(3'd1);
    send_key(10'h21C);
    send_key(10'h029);
    tick();
    check("t5_held_unmapped", held, 4'b0001);
    check("t5_count_unmapped", fifo_count, 1);
    drain(1);
    send_key(10'h11D);
    send_key(10'h023, 3); exp_q.push_back(3'd4);
    tick();
    check("t5_long_strobe_count", fifo_count, 1);
    check("t5_long_strobe_held", held, 4'b1000);
    drain(1);
    send_key(10'h123);
    check("t5_held_final", held, 0);

    // 6: asynchronous reset mid-operation, then overflow set vs clear
    send_key(10'h01D); exp_q.push_back(3'd1);
    send_key(10'h01C); exp_q.push_back(3'd3);
    send_key(10'h05A); exp_q.push_back(3'd5);
    check("t6_count_pre", fifo_count, 3);
    check("t6_held_pre", held, 4'b0101);
    rst = 1'b1;
    #2;
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_cmd", cmd, 0);
    check("t6_rst_held", held, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_overflow", overflow, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    send_key(10'h01D); exp_q.push_back(3'd1); send_key(10'h11D);
    send_key(10'h01B); exp_q.push_back(3'd2); send_key(10'h11B);
    send_key(10'h01C); exp_q.push_back(3'd3); send_key(10'h11C);
    send_key(10'h023); exp_q.push_back(3'd4); send_key(10'h123);
    check("t6_full", fifo_count, 4);
    send_key(10'h05A, 1, 1'b0, 1'b1);
    check("t6_overflow_set_wins", overflow, 1);
    check("t6_count_max", fifo_count, 4);
    send_key(10'h15A);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t6_overflow_clr", overflow, 0);
    drain(4);
    check("t6_count_drained", fifo_count, 0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
